// File: rtl/id_decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_decode_stage_pkg
// Description : Shared ISA definitions for the ID stage: opcodes, ALUOp
//               encodings, WB/M/EX control bundle layout and control decode.
// Revision    : 1.0 - initial release
// ============================================================================
package id_decode_stage_pkg;

  localparam int ADDR_W = 5;

  // Opcodes of the supported MIPS subset (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // ALUOp encodings handed to the EX stage
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // WB bundle: {RegWrite, MemtoReg}
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  // M bundle: {Branch, MemRead, MemWrite}
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;
  // EX bundle: {RegDst, ALUOp[1:0], ALUSrc}
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
  } ctrl_t;

  // Main control decode; unknown opcodes become an all-zero NOP.
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.wb[WB_REGWRITE]                = 1'b1;
        c.ex[EX_REGDST]                  = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]    = ALUOP_FUNCT;
      end
      OP_LW: begin
        c.wb[WB_REGWRITE]                = 1'b1;
        c.wb[WB_MEMTOREG]                = 1'b1;
        c.m[M_MEMREAD]                   = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]    = ALUOP_ADD;
        c.ex[EX_ALUSRC]                  = 1'b1;
      end
      OP_SW: begin
        c.m[M_MEMWRITE]                  = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]    = ALUOP_ADD;
        c.ex[EX_ALUSRC]                  = 1'b1;
      end
      OP_BEQ: begin
        c.m[M_BRANCH]                    = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]    = ALUOP_SUB;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_decode_stage_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : 32-entry register file, two asynchronous read ports with
//               write-through bypass, one synchronous write port, r0 hardwired
//               to zero, asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
  import id_decode_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wr_active;

  // r0 is never written, so its storage stays at the reset value of zero
  assign wr_active = we && (waddr != '0);

  // Next-state for the storage array: one entry updated on a live write
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_active) begin
      regs_d[waddr] = wdata;
    end
  end

  // Storage flops, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports: bypass a same-cycle write so ID sees the writeback value
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) begin
      rdata1 = (wr_active && (waddr == raddr1)) ? wdata : regs_q[raddr1];
    end
    if (raddr2 != '0) begin
      rdata2 = (wr_active && (waddr == raddr2)) ? wdata : regs_q[raddr2];
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_decode_stage
// Description : MIPS Instruction Decode stage. Decodes R/lw/sw/beq control,
//               reads the register file, sign-extends the immediate and
//               registers everything into ID/EX. Branch flush and optional
//               load-use bubble insertion.
//               Optional feature macro: HAZARD_DETECT_EN (load-use stall).
// Revision    : 1.0 - initial release
// ============================================================================
module id_decode_stage
  import id_decode_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       IF_ID_INSTR,
  input  logic [31:0]       IF_ID_NPC,
  input  logic              EX_MEM_PCSrc,
  input  logic              MEM_WB_RegWrite,
  input  logic [ADDR_W-1:0] MEM_WB_WriteReg,
  input  logic [DATA_W-1:0] MEM_WB_WriteData,
  output logic [1:0]        ID_EX_WB,
  output logic [2:0]        ID_EX_M,
  output logic [3:0]        ID_EX_EX,
  output logic [31:0]       ID_EX_NPC,
  output logic [DATA_W-1:0] ID_EX_RD1,
  output logic [DATA_W-1:0] ID_EX_RD2,
  output logic [DATA_W-1:0] ID_EX_IMM,
  output logic [ADDR_W-1:0] ID_EX_RS,
  output logic [ADDR_W-1:0] ID_EX_RT,
  output logic [ADDR_W-1:0] ID_EX_RD,
  output logic              ID_STALL
);

  // Instruction fields
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;
  ctrl_t             dec_ctrl;
  logic              stall;
  logic              bubble;

  // ID/EX pipeline register
  ctrl_t             ctrl_q,  ctrl_d;
  logic [31:0]       npc_q,   npc_d;
  logic [DATA_W-1:0] rd1_q,   rd1_d;
  logic [DATA_W-1:0] rd2_q,   rd2_d;
  logic [DATA_W-1:0] imm_q,   imm_d;
  logic [ADDR_W-1:0] rs_q,    rs_d;
  logic [ADDR_W-1:0] rt_q,    rt_d;
  logic [ADDR_W-1:0] rd_q,    rd_d;

  assign opcode  = IF_ID_INSTR[31:26];
  assign rs_addr = IF_ID_INSTR[25:21];
  assign rt_addr = IF_ID_INSTR[20:16];
  assign rd_addr = IF_ID_INSTR[15:11];
  assign imm_ext = {{(DATA_W-16){IF_ID_INSTR[15]}}, IF_ID_INSTR[15:0]};

  reg_file #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_reg_file (
    .clk    (CLK),
    .rst_n  (RST),
    .we     (MEM_WB_RegWrite),
    .waddr  (MEM_WB_WriteReg),
    .wdata  (MEM_WB_WriteData),
    .raddr1 (rs_addr),
    .raddr2 (rt_addr),
    .rdata1 (rd1_data),
    .rdata2 (rd2_data)
  );

`ifdef HAZARD_DETECT_EN
  // Load in EX whose target is a source of the instruction in ID; a branch
  // flush discards the younger instruction anyway, so no stall is needed.
  assign stall = ctrl_q.m[M_MEMREAD] && (rt_q != '0) &&
                 ((rt_q == rs_addr) || (rt_q == rt_addr)) && !EX_MEM_PCSrc;
`else
  assign stall = 1'b0;
`endif

  // Flush and stall both turn the incoming slot into a control-only bubble
  assign bubble   = EX_MEM_PCSrc || stall;
  assign dec_ctrl = decode_ctrl(opcode);

  // Next ID/EX contents: data fields always load, control zeroed on bubble
  always_comb begin
    ctrl_d = bubble ? '0 : dec_ctrl;
    npc_d  = IF_ID_NPC;
    rd1_d  = rd1_data;
    rd2_d  = rd2_data;
    imm_d  = imm_ext;
    rs_d   = rs_addr;
    rt_d   = rt_addr;
    rd_d   = rd_addr;
  end

  // ID/EX register, cleared asynchronously to a NOP bubble
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ctrl_q <= '0;
      npc_q  <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      npc_q  <= npc_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
    end
  end

  assign ID_EX_WB  = ctrl_q.wb;
  assign ID_EX_M   = ctrl_q.m;
  assign ID_EX_EX  = ctrl_q.ex;
  assign ID_EX_NPC = npc_q;
  assign ID_EX_RD1 = rd1_q;
  assign ID_EX_RD2 = rd2_q;
  assign ID_EX_IMM = imm_q;
  assign ID_EX_RS  = rs_q;
  assign ID_EX_RT  = rt_q;
  assign ID_EX_RD  = rd_q;
  assign ID_STALL  = stall;

endmodule
`default_nettype wire
